rggen_bit_field_rwle_guarded: RTL
=================================

# rggen_bit_field_rwle_guarded

Multi-channel lock/enable-gated read-write bit field with an optional two-word key guard and unlock timeout. It sits behind a register-map bit-field interface and drives `CHANNELS` independent sub-fields. Each sub-field has its own lock/enable qualifier. A write lands only when the channel qualifier matches `MODE` and, with the guard compiled in, the key guard is in its unlocked window. Blocked writes raise a one-cycle violation pulse for interrupt/status logic.

## Interface
- `MODE`, default `RGGEN_LOCK_MODE`: `rggen_rwle_mode`. Channel `c` is writable when `i_lock_or_enable[c] == MODE`.
- `CHANNELS`, default 1: number of sub-fields, ≥1.
- `WIDTH`, default 8: bits per sub-field, ≥1.
- `INITIAL_VALUE`, default `'0`: `[CHANNELS*WIDTH-1:0]` reset value. Channel `c` occupies bits `[c*WIDTH +: WIDTH]`.
- `KEY_WIDTH`, default 16: key word width.
- `KEY0`, default `16'hC0DE`: first key word.
- `KEY1`, default `16'h5AFE`: second key word. Must differ from `KEY0`.
- `TIMEOUT`, default 16: unlocked-window length in cycles, ≥1.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `i_lock_or_enable` input `CHANNELS`: per-channel lock/enable qualifier.
- `i_key_valid` input 1: key word strobe.
- `i_key` input `KEY_WIDTH`: key word.
- `bit_field_if` interface: uses `write_access`, `write_data`, `write_mask`, `value`, `read_data`.
- `o_value` output `CHANNELS*WIDTH`: field contents.
- `o_unlocked` output 1: high while the guard is in UNLOCKED.
- `o_violation` output 1: one-cycle pulse flagging a blocked write.

## Operation
- `bit_field_if.value`, `bit_field_if.read_data` and `o_value` all carry the registered value.
- `guard_open` is 1 when the state is UNLOCKED (guard compiled in), or constant 1 (guard compiled out).
- Per channel `c`, `wr_c` is asserted when all of the following hold: `write_access`, `i_lock_or_enable[c] == MODE` and `guard_open`.
- When `wr_c` is asserted: `value_c <= (value_c & ~mask_c) | (data_c & mask_c)`. Otherwise `value_c` holds.
- A violation occurs when `write_access` is asserted and some channel has `mask_c != 0` with `wr_c` deasserted. Violations are registered into `o_violation`.
- Key guard FSM states: LOCKED, KEY1_WAIT, UNLOCKED. Reset state is LOCKED.
- LOCKED transitions:
  - `i_key_valid && i_key == KEY0` → KEY1_WAIT.
  - Otherwise stay in LOCKED.
- KEY1_WAIT transitions:
  - `i_key_valid && i_key == KEY1` → UNLOCKED, with counter loaded to `TIMEOUT-1`.
  - `i_key_valid && i_key == KEY0` → stay in KEY1_WAIT.
  - `i_key_valid` with any other value → LOCKED.
  - No strobe → stay in KEY1_WAIT.
- UNLOCKED transitions (evaluated in priority order):
  1. `write_access` (accepted or not) → LOCKED. The write is consumed by the unlock.
  2. `i_key_valid` (any value) → LOCKED.
  3. Counter == 0 → LOCKED.
  4. Otherwise decrement the counter.
- The counter is `$clog2(TIMEOUT+1)` bits wide, is unsigned and never wraps. It is cleared on exit from UNLOCKED.

## Timing
- Reset values: `value = INITIAL_VALUE`, state LOCKED, counter 0, `o_unlocked = 0`, `o_violation = 0`. Reset overrides any in-flight write or key.
- A write in cycle t is visible on `o_value` in cycle t+1.
- Key sequence: `KEY0` in cycle t, `KEY1` in cycle t+1 or later, then `o_unlocked = 1` from cycle t+2. With no further events, UNLOCKED lasts exactly `TIMEOUT` cycles.
- The gate uses the current state. When a write and a key arrive in the same cycle in UNLOCKED, the write is accepted and the next state is LOCKED. When a write and `KEY1` arrive in the same cycle in KEY1_WAIT, the write is blocked (violation) and the next state is UNLOCKED.
- `o_violation` asserts in the cycle after the blocked write, for exactly one cycle per blocked write.
- Channel qualifiers are sampled in the write cycle only. There is no pipelining.

## Configuration
- `RGGEN_BIT_FIELD_KEY_GUARD_EN`
- Defined: the FSM and counter are built, and gating is as above.
- Undefined:
  - No FSM and no counter.
  - `guard_open = 1` and `o_unlocked` is tied to 1.
  - `i_key_valid` and `i_key` are ignored.
  - Violations arise only from lock/enable mismatch.
  - Behaviour equals a per-channel rwl/rwe field.

## Structure
- `rggen_rtl_pkg` gains the typedef `rggen_key_guard_state` (enum: LOCKED, KEY1_WAIT, UNLOCKED). It reuses the existing `rggen_rwle_mode`.
- Sub-module `rggen_key_guard` (parameters `KEY_WIDTH`, `KEY0`, `KEY1`, `TIMEOUT`) holds the FSM and counter.
  - Inputs: `clk`, `rst`, `i_key_valid`, `i_key`, `i_write_access`.
  - Output: `o_unlocked`.
  - It is instantiated only under the macro.
- Top level: per-channel value registers in a generate loop, plus violation logic.

## Test plan
- Reset, `INITIAL_VALUE = 16'hA55A`, `CHANNELS = 2`, `WIDTH = 8` → `o_value = 16'hA55A`, `o_unlocked = 0`, `o_violation = 0`.
- Guard off, `MODE = LOCK`, `i_lock_or_enable = 2'b01`, write `16'hFFFF` with mask `16'hFFFF`:
  - Required: `o_value = 16'hFF5A` after 1 cycle (channel 0 locked keeps `8'h5A`; channel 1 takes `8'hFF`).
  - Required: `o_violation` pulses.
- Guard on, `KEY0` then `KEY1`, then a write of `16'h1234` with mask `16'hFFFF` → value `16'h1234`, `o_unlocked` drops the next cycle, and a second write is blocked with a violation.
- Guard on, `TIMEOUT = 4`, key sequence with no write → `o_unlocked` is high for exactly 4 cycles. A write in cycle 5 is blocked and the value holds.
- `KEY0`, then `16'h0000`, then `KEY1` → state stays LOCKED, and a write is blocked.
- Assert `rst` in UNLOCKED while a write is pending → next cycle: value = `INITIAL_VALUE`, `o_unlocked = 0`, no violation.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared rggen types: lock/enable qualifier polarity and key guard FSM states.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_LOCK_MODE,
    RGGEN_ENABLE_MODE
  } rggen_rwle_mode;

  typedef enum logic [1:0] {
    LOCKED,
    KEY1_WAIT,
    UNLOCKED
  } rggen_key_guard_state;

endpackage

// File: rtl/rggen_bit_field_if.sv
// Register-map bit-field access interface (write strobe/data/mask, value readback).
interface rggen_bit_field_if #(
  parameter int WIDTH = 32
);
  logic             write_access;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] read_data;

  modport bit_field (
    input  write_access,
    input  write_data,
    input  write_mask,
    output value,
    output read_data
  );
endinterface

// File: rtl/rggen_key_guard.sv
// Two-word key guard: KEY0 then KEY1 opens a TIMEOUT-cycle window that any write
// or key strobe closes early.
module rggen_key_guard
  import rggen_rtl_pkg::*;
#(
  parameter int                   KEY_WIDTH = 16,
  parameter logic [KEY_WIDTH-1:0] KEY0      = 16'hC0DE,
  parameter logic [KEY_WIDTH-1:0] KEY1      = 16'h5AFE,
  parameter int                   TIMEOUT   = 16
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_key_valid,
  input  logic [KEY_WIDTH-1:0] i_key,
  input  logic                 i_write_access,
  output logic                 o_unlocked
);
  localparam int CW = $clog2(TIMEOUT + 1);

  rggen_key_guard_state state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOCKED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      LOCKED: begin
        if (i_key_valid && (i_key == KEY0)) state_nxt = KEY1_WAIT;
      end
      KEY1_WAIT: begin
        if (i_key_valid) begin
          if (i_key == KEY1) begin
            state_nxt = UNLOCKED;
            cnt_nxt   = CW'(TIMEOUT - 1);
          end else if (i_key != KEY0) begin
            state_nxt = LOCKED;
          end
        end
      end
      UNLOCKED: begin
        // any access ends the window, so one unlock buys at most one write
        if (i_write_access || i_key_valid || (cnt == '0)) begin
          state_nxt = LOCKED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = LOCKED;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign o_unlocked = (state == UNLOCKED);

endmodule

// File: rtl/rggen_bit_field_rwle_guarded.sv
// Multi-channel lock/enable gated RW bit field; the key guard is built only when
// RGGEN_BIT_FIELD_KEY_GUARD_EN is defined.
module rggen_bit_field_rwle_guarded
  import rggen_rtl_pkg::*;
#(
  parameter rggen_rwle_mode                MODE          = RGGEN_LOCK_MODE,
  parameter int                            CHANNELS      = 1,
  parameter int                            WIDTH         = 8,
  parameter logic [CHANNELS*WIDTH-1:0]     INITIAL_VALUE = '0,
  parameter int                            KEY_WIDTH     = 16,
  parameter logic [KEY_WIDTH-1:0]          KEY0          = 16'hC0DE,
  parameter logic [KEY_WIDTH-1:0]          KEY1          = 16'h5AFE,
  parameter int                            TIMEOUT       = 16
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       i_lock_or_enable,
  input  logic                      i_key_valid,
  input  logic [KEY_WIDTH-1:0]      i_key,
  rggen_bit_field_if.bit_field      bit_field_if,
  output logic [CHANNELS*WIDTH-1:0] o_value,
  output logic                      o_unlocked,
  output logic                      o_violation
);
  logic                               guard_open;
  logic [CHANNELS-1:0]                wr;
  logic [CHANNELS-1:0]                blocked;
  logic [CHANNELS-1:0][WIDTH-1:0]     value_q;

`ifdef RGGEN_BIT_FIELD_KEY_GUARD_EN
  rggen_key_guard #(
    .KEY_WIDTH (KEY_WIDTH),
    .KEY0      (KEY0),
    .KEY1      (KEY1),
    .TIMEOUT   (TIMEOUT)
  ) u_key_guard (
    .clk            (clk),
    .rst            (rst),
    .i_key_valid    (i_key_valid),
    .i_key          (i_key),
    .i_write_access (bit_field_if.write_access),
    .o_unlocked     (o_unlocked)
  );
  assign guard_open = o_unlocked;
`else
  logic unused_key;
  assign unused_key = ^{i_key_valid, i_key};
  assign guard_open = 1'b1;
  assign o_unlocked = 1'b1;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] mask_c;
    logic [WIDTH-1:0] data_c;
    assign mask_c = bit_field_if.write_mask[c*WIDTH +: WIDTH];
    assign data_c = bit_field_if.write_data[c*WIDTH +: WIDTH];

    assign wr[c] = bit_field_if.write_access &&
                   (i_lock_or_enable[c] == logic'(MODE)) && guard_open;
    // a zero-mask channel is not touched, so it cannot be blocked
    assign blocked[c] = bit_field_if.write_access && (|mask_c) && !wr[c];

    always_ff @(posedge clk) begin
      if (rst) value_q[c] <= INITIAL_VALUE[c*WIDTH +: WIDTH];
      else if (wr[c]) value_q[c] <= (value_q[c] & ~mask_c) | (data_c & mask_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) o_violation <= 1'b0;
    else     o_violation <= |blocked;
  end

  assign o_value                = value_q;
  assign bit_field_if.value     = value_q;
  assign bit_field_if.read_data = value_q;

endmodule
